// File: rtl/imem_loadable.sv
// imem_loadable: loadable instruction memory with a pipelined, fixed-latency fetch port.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module imem_loadable #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  load_err,
    input  logic                  dbg_flip_parity,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] PC,
    output logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH:0]   prog_length,
    output logic                  busy,
    output logic                  parity_err
);

`ifdef IMEM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int MW  = DATA_WIDTH + PW;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CLR_LAST = AW1'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ONE      = AW1'(1);

    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_DRAIN, S_LOAD} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] clr_cnt;
    logic [MW-1:0]       mem [DEPTH];

    logic                we;
    logic [IW-1:0]       waddr;
    logic [MW-1:0]       wdata;
    logic                load_ok;
    logic                fire;
    logic                in_flight;
    logic [MW-1:0]       rd_word;
    logic                rd_ok;
    logic                rd_bad;

    logic [READ_LATENCY-1:0] pv;
    logic [READ_LATENCY-1:0] pe;
    logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

    assign load_ok = ({1'b0, load_addr} < DEPTH_W);
    assign fire    = fetch_req && fetch_ready;

    always_comb begin
        we    = rst_n && ((state == S_CLEAR) || ((state == S_LOAD) && load_valid && load_ok));
        waddr = (state == S_CLEAR) ? clr_cnt[IW-1:0] : load_addr[IW-1:0];
        wdata = '0;
        if (state != S_CLEAR) begin
`ifdef IMEM_PARITY_EN
            wdata = {(^load_data) ^ dbg_flip_parity, load_data};
`else
            wdata = load_data;
`endif
        end
    end

`ifndef IMEM_PARITY_EN
    logic unused_flip;
    assign unused_flip = dbg_flip_parity;
`endif

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Stored parity makes the whole word even, so any odd reduction is an error.
    always_comb begin
        rd_word = mem[PC[IW-1:0]];
        rd_ok   = ({1'b0, PC} < DEPTH_W) && ({1'b0, PC} < prog_length);
`ifdef IMEM_PARITY_EN
        rd_bad  = ^rd_word;
`else
        rd_bad  = 1'b0;
`endif
    end

    // Only stages before the output stage count as in flight; the output
    // stage's inst_valid is delivered in the current cycle.
    always_comb begin
        in_flight = 1'b0;
        for (int unsigned i = 0; i + 1 < READ_LATENCY; i++) begin
            in_flight = in_flight | pv[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            pe <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
        end else begin
            pv[0] <= fire;
            pe[0] <= fire && rd_ok && rd_bad;
            if (fire) pd[0] <= (rd_ok && !rd_bad) ? rd_word[DATA_WIDTH-1:0] : '0;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
        end
    end

    assign inst_valid  = pv[READ_LATENCY-1];
    assign parity_err  = pe[READ_LATENCY-1];
    assign Instruction = pd[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_CLEAR;
            clr_cnt     <= '0;
            prog_length <= '0;
            load_ready  <= 1'b0;
            fetch_ready <= 1'b0;
            busy        <= 1'b1;
            load_err    <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state       <= S_RUN;
                        fetch_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + ONE;
                    end
                end
                S_RUN: begin
                    if (load_start) begin
                        state       <= S_DRAIN;
                        fetch_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!in_flight) begin
                        state       <= S_LOAD;
                        load_ready  <= 1'b1;
                        prog_length <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        if (load_ok) begin
                            if (({1'b0, load_addr} + ONE) > prog_length)
                                prog_length <= {1'b0, load_addr} + ONE;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                    if (load_done) begin
                        state       <= S_RUN;
                        load_ready  <= 1'b0;
                        fetch_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule
